// File: rtl/rx_detect_sequencer.sv
// Receiver-detection sequencer: drives TX common-mode and detect pulses, samples lane
// comparators, and applies the two-pass confirm rule before reporting the lane mask.
module rx_detect_sequencer #(
   parameter int NUM_LANES         = 1,
   parameter int SETTLE_CYCLES     = 16,
   parameter int CHARGE_CYCLES     = 8,
   parameter int RETRY_WAIT_CYCLES = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [NUM_LANES-1:0] rx_detect_sense_i,
   output logic                 tx_cm_en_o,
   output logic [NUM_LANES-1:0] tx_detect_pulse_o,
   output logic [NUM_LANES-1:0] lane_detect_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int MAX_A = (SETTLE_CYCLES > CHARGE_CYCLES) ? SETTLE_CYCLES : CHARGE_CYCLES;
   localparam int MAX_CYC = (MAX_A > RETRY_WAIT_CYCLES) ? MAX_A : RETRY_WAIT_CYCLES;
   localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CHARGE_LD = CNT_W'(CHARGE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RETRY_LD  = CNT_W'(RETRY_WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, CM_SETTLE, PULSE, EVAL, WAIT_RETRY, DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 pass_q, pass_d;
   logic [NUM_LANES-1:0] pass1_mask_q, pass1_mask_d;
   logic [NUM_LANES-1:0] sample_mask_q, sample_mask_d;
   logic [NUM_LANES-1:0] lane_detect_q, lane_detect_d;
   logic [NUM_LANES-1:0] confirm_mask;
   logic                 cnt_last;

   assign cnt_last     = (cnt_q == '0);
   assign confirm_mask = pass1_mask_q & sample_mask_q;

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      pass_d            = pass_q;
      pass1_mask_d      = pass1_mask_q;
      sample_mask_d     = sample_mask_q;
      lane_detect_d     = lane_detect_q;
      tx_cm_en_o        = 1'b0;
      tx_detect_pulse_o = '0;
      busy_o            = (state_q != IDLE);
      done_o            = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d       = CM_SETTLE;
               cnt_d         = SETTLE_LD;
               pass_d        = 1'b0;
               lane_detect_d = '0;
            end
         end
         CM_SETTLE: begin
            tx_cm_en_o = 1'b1;
            if (cnt_last) begin
               state_d = PULSE;
               cnt_d   = CHARGE_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         PULSE: begin
            tx_cm_en_o        = 1'b1;
            tx_detect_pulse_o = '1;
            // Only the fully charged, final pulse cycle gives a trustworthy comparator reading.
            if (cnt_last) begin
               state_d       = EVAL;
               sample_mask_d = rx_detect_sense_i;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         EVAL: begin
            tx_cm_en_o = 1'b1;
            if (!pass_q) begin
               if (&sample_mask_q) begin
                  state_d       = DONE;
                  lane_detect_d = sample_mask_q;
               end else begin
                  state_d = WAIT_RETRY;
                  cnt_d   = RETRY_LD;
                  if (sample_mask_q != '0) begin
                     pass1_mask_d = sample_mask_q;
                     pass_d       = 1'b1;
                  end
               end
            end else if (confirm_mask != '0) begin
               state_d       = DONE;
               lane_detect_d = confirm_mask;
            end else begin
               // No lane confirmed twice: start over with a fresh first pass.
               state_d = WAIT_RETRY;
               cnt_d   = RETRY_LD;
               pass_d  = 1'b0;
            end
         end
         WAIT_RETRY: begin
            tx_cm_en_o = 1'b1;
            if (cnt_last) begin
               state_d = PULSE;
               cnt_d   = CHARGE_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            tx_cm_en_o = 1'b1;
            done_o     = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides any transition, including an EVAL that would complete.
      if (abort_i && (state_q != IDLE)) begin
         state_d       = IDLE;
         lane_detect_d = lane_detect_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         pass_q        <= 1'b0;
         pass1_mask_q  <= '0;
         sample_mask_q <= '0;
         lane_detect_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pass_q        <= pass_d;
         pass1_mask_q  <= pass1_mask_d;
         sample_mask_q <= sample_mask_d;
         lane_detect_q <= lane_detect_d;
      end
   end

   assign lane_detect_o = lane_detect_q;

endmodule

// File: tb/tb_rx_detect_sequencer.sv
// Bench for rx_detect_sequencer: per-pass sense masks are planned by a pass-list model
// that derives the completion cycle and result; every cycle's outputs are checked.
module tb_rx_detect_sequencer;

   localparam int NL = 4;
   localparam int S  = 4;
   localparam int C  = 3;
   localparam int R  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [NL-1:0] sense = '0;
   logic          cm_en;
   logic [NL-1:0] pulse;
   logic [NL-1:0] lane;
   logic          busy;
   logic          done;

   int n_vec = 0;
   int n_err = 0;
   logic [NL-1:0] last_res = '0;
   logic [NL-1:0] pm [8];

   rx_detect_sequencer #(
      .NUM_LANES(NL), .SETTLE_CYCLES(S), .CHARGE_CYCLES(C), .RETRY_WAIT_CYCLES(R)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .rx_detect_sense_i(sense), .tx_cm_en_o(cm_en), .tx_detect_pulse_o(pulse),
      .lane_detect_o(lane), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pass-list model: first pass accepts all-ones; a partial first pass must be
   // confirmed by a nonzero AND on the next pass, otherwise the pair is discarded.
   task automatic plan(output int np, output logic [NL-1:0] res);
      bit            have = 1'b0;
      logic [NL-1:0] pend = '0;
      np  = 8;
      res = '0;
      for (int k = 0; k < 8; k++) begin
         if (!have) begin
            if (pm[k] == '1) begin np = k + 1; res = pm[k]; return; end
            if (pm[k] != '0) begin have = 1'b1; pend = pm[k]; end
         end else begin
            if ((pend & pm[k]) != '0) begin np = k + 1; res = pend & pm[k]; return; end
            have = 1'b0;
         end
      end
   endtask

   task automatic setm(input logic [NL-1:0] a, b, c, d);
      for (int i = 0; i < 8; i++) pm[i] = '0;
      pm[0] = a; pm[1] = b; pm[2] = c; pm[3] = d;
   endtask

   task automatic run_seq(input int abort_t, input int rst_t, input bit keep_start);
      int            np, td, stop_t, pk, kk;
      bit            in_pulse, fin;
      logic [NL-1:0] res, exp_lane;
      pm[7] = '1;
      plan(np, res);
      td = S + np * C + (np - 1) * (R + 1) + 2;
      stop_t = td;
      if (abort_t >= 0 && abort_t < stop_t) stop_t = abort_t;
      if (rst_t >= 0 && rst_t < stop_t) stop_t = rst_t;
      start = 1'b1;
      for (int t = 0; t <= stop_t; t++) begin
         if (t > 0) begin
            @(posedge clk); #1;
            if (!keep_start) start = 1'b0;
         end
         in_pulse = 1'b0; fin = 1'b0; kk = 0;
         for (int k = 0; k < np; k++) begin
            pk = S + 1 + k * (C + 1 + R);
            if (t >= pk && t < pk + C) begin
               in_pulse = 1'b1; kk = k; fin = (t == pk + C - 1);
            end
         end
         sense = in_pulse ? (fin ? pm[kk] : ~pm[kk]) : NL'($urandom);
         abort = (t == abort_t);
         rst_n = !(t == rst_t);
         exp_lane = (t == 0) ? last_res : ((t < td) ? '0 : res);
         chk("cm_en",  8'(cm_en), 8'(t >= 1));
         chk("busy",   8'(busy),  8'(t >= 1));
         chk("pulse",  8'(pulse), in_pulse ? 8'(4'hF) : 8'h00);
         chk("done",   8'(done),  8'(t == td));
         chk("lane",   8'(lane),  8'(exp_lane));
      end
      @(posedge clk); #1;
      abort = 1'b0;
      rst_n = 1'b1;
      if (!keep_start) start = 1'b0;
      last_res = (stop_t == td) ? res : '0;
      chk("end_cm",    8'(cm_en), 8'h00);
      chk("end_busy",  8'(busy),  8'h00);
      chk("end_done",  8'(done),  8'h00);
      chk("end_pulse", 8'(pulse), 8'h00);
      chk("end_lane",  8'(lane),  8'(last_res));
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cm",   8'(cm_en), 8'h00);
      chk("rst_busy", 8'(busy),  8'h00);
      chk("rst_done", 8'(done),  8'h00);
      chk("rst_lane", 8'(lane),  8'h00);
      rst_n = 1'b1;
      @(posedge clk); #1;

      setm(4'b1111, 4'b0000, 4'b0000, 4'b0000); run_seq(-1, -1, 1'b0);
      setm(4'b0101, 4'b0111, 4'b0000, 4'b0000); run_seq(-1, -1, 1'b0);
      setm(4'b0000, 4'b0000, 4'b0000, 4'b1111); run_seq(-1, -1, 1'b0);
      setm(4'b1110, 4'b1110, 4'b0000, 4'b0000); run_seq(-1, -1, 1'b0);
      setm(4'b0011, 4'b1100, 4'b1111, 4'b0000); run_seq(-1, -1, 1'b0);
      setm(4'b1000, 4'b1001, 4'b0000, 4'b0000); run_seq(-1, -1, 1'b0);

      // abort in the retry wait, abort racing a completing EVAL, reset during PULSE
      setm(4'b0101, 4'b0101, 4'b0000, 4'b0000); run_seq(S + C + 4, -1, 1'b0);
      setm(4'b1111, 4'b0000, 4'b0000, 4'b0000); run_seq(S + C + 1, -1, 1'b0);
      setm(4'b1111, 4'b0000, 4'b0000, 4'b0000); run_seq(-1, S + 2, 1'b0);

      setm(4'b1111, 4'b0000, 4'b0000, 4'b0000); run_seq(-1, -1, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("idle_rst_lane", 8'(lane), 8'h00);
      last_res = '0;

      setm(4'b0110, 4'b0010, 4'b0000, 4'b0000); run_seq(-1, -1, 1'b1);
      setm(4'b1111, 4'b0000, 4'b0000, 4'b0000); run_seq(-1, -1, 1'b1);
      setm(4'b0001, 4'b0011, 4'b0000, 4'b0000); run_seq(-1, -1, 1'b0);

      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < 8; i++) pm[i] = NL'($urandom);
         run_seq(-1, -1, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
